// File: rtl/mmio_pkg.sv
// Shared constants for the timer/console MMIO block: register offsets,
// STATUS bit positions, window size and the byte-lane merge helper.
package mmio_pkg;

    localparam int WIN_BITS = 5;

    localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] OFF_TX_DATA     = 3'd4;
    localparam logic [2:0] OFF_STATUS      = 3'd5;
    localparam logic [2:0] OFF_CTRL        = 3'd6;
    localparam logic [2:0] OFF_RSVD        = 3'd7;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_PENDING   = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 4;

    // Replace only the byte lanes selected by the write strobe.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lanes);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small circular FIFO with occupancy count; a push while full is accepted
// only when a pop frees the head slot in the same cycle.
module byte_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign full      = (count_r == CNT_MAX);
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign head      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // Storage carries no reset; stale entries are hidden by the empty mask.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_timer_uart.sv
// Data-side MMIO responder: 64-bit machine timer with compare interrupt and a
// TX byte FIFO drained over a valid/ready console stream.
module mmio_timer_uart
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          TX_DEPTH  = 4,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  byte_en,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        timer_irq
);

    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CNT_W = $clog2(TX_DEPTH + 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

    logic [63:0]      mtime_r;
    logic [63:0]      mtimecmp_r;
    logic [PS_W-1:0]  ps_cnt_r;
    logic [31:0]      ctrl_r;
    logic             pending_r;
    logic             overflow_r;
    logic [31:0]      rd_data_r;
    logic             rd_hit_r;

    logic             rd_win_s;
    logic [2:0]       rd_off_s;
    logic             wr_hit_s;
    logic [2:0]       wr_off_s;
    logic             wr_mtime_lo_s;
    logic             wr_mtime_hi_s;
    logic             wr_cmp_lo_s;
    logic             wr_cmp_hi_s;
    logic             wr_tx_s;
    logic             wr_status_s;
    logic             wr_ctrl_s;
    logic [63:0]      mtime_nxt_s;
    logic [PS_W-1:0]  ps_nxt_s;
    logic [31:0]      status_s;
    logic [31:0]      rd_word_s;
    logic             push_s;
    logic             pop_s;
    logic             ovf_set_s;
    logic             ovf_clr_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [7:0]       fifo_head_s;
    logic             unused_addr_bits_s;

    assign rd_win_s = (rd_addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign rd_off_s = rd_addr[WIN_BITS-1:2];
    assign wr_hit_s = wr_en & (wr_addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign wr_off_s = wr_addr[WIN_BITS-1:2];

    assign wr_mtime_lo_s = wr_hit_s & (wr_off_s == OFF_MTIME_LO);
    assign wr_mtime_hi_s = wr_hit_s & (wr_off_s == OFF_MTIME_HI);
    assign wr_cmp_lo_s   = wr_hit_s & (wr_off_s == OFF_MTIMECMP_LO);
    assign wr_cmp_hi_s   = wr_hit_s & (wr_off_s == OFF_MTIMECMP_HI);
    assign wr_tx_s       = wr_hit_s & (wr_off_s == OFF_TX_DATA);
    assign wr_status_s   = wr_hit_s & (wr_off_s == OFF_STATUS);
    assign wr_ctrl_s     = wr_hit_s & (wr_off_s == OFF_CTRL);

    assign unused_addr_bits_s = ^{rd_addr[1:0], wr_addr[1:0]};

    assign pop_s     = ~fifo_empty_s & tx_ready;
    assign push_s    = wr_tx_s & byte_en[0];
    assign ovf_set_s = push_s & fifo_full_s & ~pop_s;
    assign ovf_clr_s = wr_status_s & byte_en[0] & wr_data[ST_OVERFLOW];

    assign rd_data   = rd_data_r;
    assign rd_hit    = rd_hit_r;
    assign tx_valid  = ~fifo_empty_s;
    assign tx_data   = fifo_head_s;
    assign timer_irq = pending_r & ctrl_r[0];

    byte_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (wr_data[7:0]),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

    // Next mtime: a software write to either half replaces this cycle's tick.
    always_comb begin
        mtime_nxt_s = mtime_r;
        ps_nxt_s    = ps_cnt_r;
        if (wr_mtime_lo_s) begin
            mtime_nxt_s[31:0] = lane_merge(mtime_r[31:0], wr_data, byte_en);
            ps_nxt_s          = {PS_W{1'b0}};
        end else if (wr_mtime_hi_s) begin
            mtime_nxt_s[63:32] = lane_merge(mtime_r[63:32], wr_data, byte_en);
            ps_nxt_s           = {PS_W{1'b0}};
        end else if (ps_cnt_r == PS_LAST) begin
            mtime_nxt_s = mtime_r + 64'd1;
            ps_nxt_s    = {PS_W{1'b0}};
        end else begin
            ps_nxt_s = ps_cnt_r + PS_ONE;
        end
    end

    // STATUS word assembly.
    always_comb begin
        status_s                     = 32'd0;
        status_s[ST_FULL]            = fifo_full_s;
        status_s[ST_EMPTY]           = fifo_empty_s;
        status_s[ST_PENDING]         = pending_r;
        status_s[ST_OVERFLOW]        = overflow_r;
        status_s[ST_COUNT_LSB +: 4]  = 4'(fifo_count_s);
    end

    // Read mux over pre-write register values.
    always_comb begin
        rd_word_s = 32'd0;
        if (rd_win_s) begin
            case (rd_off_s)
                OFF_MTIME_LO:    rd_word_s = mtime_r[31:0];
                OFF_MTIME_HI:    rd_word_s = mtime_r[63:32];
                OFF_MTIMECMP_LO: rd_word_s = mtimecmp_r[31:0];
                OFF_MTIMECMP_HI: rd_word_s = mtimecmp_r[63:32];
                OFF_STATUS:      rd_word_s = status_s;
                OFF_CTRL:        rd_word_s = ctrl_r;
                OFF_TX_DATA:     rd_word_s = 32'd0;
                OFF_RSVD:        rd_word_s = 32'd0;
                default:         rd_word_s = 32'd0;
            endcase
        end else begin
            rd_word_s = 32'd0;
        end
    end

    // Registered read response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= 32'd0;
            rd_hit_r  <= 1'b0;
        end else begin
            rd_data_r <= rd_word_s;
            rd_hit_r  <= rd_win_s;
        end
    end

    // Timer counter, prescaler and the one-cycle-late compare result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_r   <= 64'd0;
            ps_cnt_r  <= {PS_W{1'b0}};
            pending_r <= 1'b0;
        end else begin
            mtime_r   <= mtime_nxt_s;
            ps_cnt_r  <= ps_nxt_s;
            pending_r <= (mtime_r >= mtimecmp_r);
        end
    end

    // Software-visible compare, control and sticky overflow state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl_r     <= 32'd0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_cmp_lo_s) begin
                mtimecmp_r[31:0] <= lane_merge(mtimecmp_r[31:0], wr_data, byte_en);
            end else if (wr_cmp_hi_s) begin
                mtimecmp_r[63:32] <= lane_merge(mtimecmp_r[63:32], wr_data, byte_en);
            end else begin
                mtimecmp_r <= mtimecmp_r;
            end
            if (wr_ctrl_s) begin
                ctrl_r <= lane_merge(ctrl_r, wr_data, byte_en);
            end else begin
                ctrl_r <= ctrl_r;
            end
            // A new overflow beats a simultaneous clear.
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr_s) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer_uart.sv
// Directed bench for mmio_timer_uart with a queue-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_mmio_timer_uart;

    localparam logic [31:0] BASE     = 32'h1000_0000;
    localparam int          DEPTH    = 4;
    localparam int          PRESCALE = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rd_addr = 32'd0;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = 32'd0;
    logic [31:0] wr_data = 32'd0;
    logic [3:0]  byte_en = 4'd0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        timer_irq;

    always #5 clk = ~clk;

    mmio_timer_uart #(
        .BASE_ADDR (BASE),
        .TX_DEPTH  (DEPTH),
        .PRESCALE  (PRESCALE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_hit    (rd_hit),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .byte_en   (byte_en),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .timer_irq (timer_irq)
    );

    // Reference model state
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic [31:0] m_ctrl;
    logic        m_pend;
    logic        m_ovf;
    int          m_ps;
    logic [7:0]  m_q[$];
    logic [31:0] m_rd_data;
    logic        m_rd_hit;

    int n_tests = 0;
    int n_fail  = 0;
    bit found;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    function automatic logic [31:0] reg_value(input logic [2:0] off);
        int sz;
        sz = m_q.size();
        case (off)
            3'd0: return m_mtime[31:0];
            3'd1: return m_mtime[63:32];
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd5: return 32'(sz * 16) | (m_ovf ? 32'd8 : 32'd0) | (m_pend ? 32'd4 : 32'd0)
                         | ((sz == 0) ? 32'd2 : 32'd0) | ((sz == DEPTH) ? 32'd1 : 32'd0);
            3'd6: return m_ctrl;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mtime = 64'd0;
        m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
        m_ctrl = 32'd0;
        m_pend = 1'b0;
        m_ovf = 1'b0;
        m_ps = 0;
        m_q.delete();
        m_rd_data = 32'd0;
        m_rd_hit = 1'b0;
    endtask

    task automatic compare_all();
        chk("rd_data", rd_data, m_rd_data);
        chk("rd_hit", rd_hit, m_rd_hit);
        chk("tx_valid", tx_valid, m_q.size() != 0);
        chk("tx_data", tx_data, (m_q.size() != 0) ? m_q[0] : 8'd0);
        chk("timer_irq", timer_irq, m_pend & m_ctrl[0]);
    endtask

    // Advance one clock: predict from current inputs, then compare after the edge.
    task automatic tick();
        logic [63:0] n_mtime, n_cmp;
        logic [31:0] n_ctrl, n_rd_data;
        logic        n_rd_hit, n_pend, n_ovf, hit_w, do_pop, do_push, was_full;
        logic [2:0]  off_w;
        int          n_ps;
        if (!rst_n) begin
            @(posedge clk);
            model_reset();
            #1;
            return;
        end
        n_rd_hit  = (rd_addr[31:5] == BASE[31:5]);
        n_rd_data = n_rd_hit ? reg_value(rd_addr[4:2]) : 32'd0;
        n_pend    = (m_mtime >= m_cmp);
        n_cmp     = m_cmp;
        n_ctrl    = m_ctrl;
        if (m_ps == PRESCALE - 1) begin
            n_mtime = m_mtime + 64'd1;
            n_ps = 0;
        end else begin
            n_mtime = m_mtime;
            n_ps = m_ps + 1;
        end
        hit_w    = wr_en && (wr_addr[31:5] == BASE[31:5]);
        off_w    = wr_addr[4:2];
        do_pop   = (m_q.size() != 0) && tx_ready;
        do_push  = hit_w && off_w == 3'd4 && byte_en[0];
        was_full = (m_q.size() == DEPTH);
        n_ovf    = m_ovf;
        if (hit_w) begin
            case (off_w)
                3'd0: begin n_mtime = {m_mtime[63:32], bmerge(m_mtime[31:0], wr_data, byte_en)}; n_ps = 0; end
                3'd1: begin n_mtime = {bmerge(m_mtime[63:32], wr_data, byte_en), m_mtime[31:0]}; n_ps = 0; end
                3'd2: n_cmp = {m_cmp[63:32], bmerge(m_cmp[31:0], wr_data, byte_en)};
                3'd3: n_cmp = {bmerge(m_cmp[63:32], wr_data, byte_en), m_cmp[31:0]};
                3'd5: if (byte_en[0] && wr_data[3]) n_ovf = 1'b0;
                3'd6: n_ctrl = bmerge(m_ctrl, wr_data, byte_en);
                default: ;
            endcase
        end
        @(posedge clk);
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            if (!was_full || do_pop) m_q.push_back(wr_data[7:0]);
            else n_ovf = 1'b1;
        end
        m_mtime = n_mtime; m_cmp = n_cmp; m_ctrl = n_ctrl; m_pend = n_pend;
        m_ovf = n_ovf; m_ps = n_ps; m_rd_data = n_rd_data; m_rd_hit = n_rd_hit;
        #1;
        compare_all();
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = BASE + off; wr_data = data; byte_en = be;
        tick();
        wr_en = 1'b0; byte_en = 4'd0;
    endtask

    task automatic rd_lit(input logic [31:0] addr, input logic [31:0] mask,
                          input logic [31:0] exp, input logic exp_hit, input string name);
        rd_addr = addr;
        tick();
        chk(name, rd_data & mask, exp);
        chk({name, "_hit"}, rd_hit, exp_hit);
    endtask

    initial begin
        model_reset();
        repeat (2) tick();
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_rd_hit", rd_hit, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'd0);
        chk("rst_timer_irq", timer_irq, 1'b0);
        rst_n = 1'b1;

        // Reset values of the compare register and out-of-window reads
        rd_lit(BASE + 32'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "cmp_lo_rst");
        rd_lit(BASE + 32'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "cmp_hi_rst");
        rd_lit(BASE + 32'h40, 32'hFFFF_FFFF, 32'd0, 1'b0, "out_of_window");
        rd_lit(BASE + 32'h1F, 32'hFFFF_FFFF, 32'd0, 1'b1, "reserved_rd");

        // Carry from MTIME_LO into MTIME_HI
        wr(32'h00, 32'hFFFF_FFFE, 4'hF);
        wr(32'h04, 32'h0000_0000, 4'hF);
        rd_addr = BASE + 32'h04;
        tick(); tick(); tick();
        chk("mtime_hi_carry", rd_data, 32'd1);

        // Byte-lane write to CTRL
        wr(32'h18, 32'h1234_5600, 4'hF);
        wr(32'h18, 32'h0000_00AB, 4'b0001);
        rd_lit(BASE + 32'h18, 32'hFFFF_FFFF, 32'h1234_56AB, 1'b1, "ctrl_lane0");
        wr(32'h18, 32'h0000_0000, 4'hF);

        // Timer compare interrupt
        wr(32'h04, 32'd0, 4'hF);
        wr(32'h00, 32'd0, 4'hF);
        wr(32'h0C, 32'd0, 4'hF);
        wr(32'h08, 32'd20, 4'hF);
        wr(32'h18, 32'd1, 4'b0001);
        rd_addr = BASE;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (timer_irq) found = 1'b1;
        end
        chk("irq_rise_seen", found, 1'b1);
        chk("irq_at_mtime20", rd_data, 32'd20);
        wr(32'h08, 32'd100, 4'hF);
        chk("irq_lags_cmp_write", timer_irq, 1'b1);
        tick();
        chk("irq_drop", timer_irq, 1'b0);

        // Overfill the FIFO with the sink stalled, then drain
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(32'h10, 32'h41 + 32'(i), 4'b0001);
        rd_lit(BASE + 32'h14, 32'hFB, 32'h49, 1'b1, "status_full_ovf");
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", tx_valid, 1'b1);
            chk("drain_byte", tx_data, 8'h41 + 8'(i));
            tick();
        end
        chk("drained_valid", tx_valid, 1'b0);
        rd_lit(BASE + 32'h14, 32'hFB, 32'h0A, 1'b1, "status_empty");

        // Clear overflow, then push into a full FIFO while popping
        wr(32'h14, 32'h8, 4'b0001);
        rd_lit(BASE + 32'h14, 32'hFB, 32'h02, 1'b1, "status_ovf_clr");
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(32'h10, 32'h61 + 32'(i), 4'b0001);
        wr(32'h10, 32'h0000_FF00, 4'b0010);
        tx_ready = 1'b1;
        wr(32'h10, 32'h55, 4'b0001);
        tx_ready = 1'b0;
        rd_lit(BASE + 32'h14, 32'hFB, 32'h41, 1'b1, "status_push_pop_full");
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain2_byte", tx_data, (i == 3) ? 8'h55 : 8'h62 + 8'(i));
            tick();
        end
        tx_ready = 1'b0;

        // Asynchronous reset mid-stream
        wr(32'h08, 32'd0, 4'hF);
        for (int i = 0; i < 3; i++) wr(32'h10, 32'h71 + 32'(i), 4'b0001);
        wr(32'h00, 32'd1234, 4'hF);
        chk("pre_rst_irq", timer_irq, 1'b1);
        chk("pre_rst_valid", tx_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", tx_valid, 1'b0);
        chk("async_rst_irq", timer_irq, 1'b0);
        chk("async_rst_hit", rd_hit, 1'b0);
        chk("async_rst_data", rd_data, 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
        rd_lit(BASE + 32'h00, 32'hFFFF_FFFF, 32'd0, 1'b1, "mtime_lo_after_rst");
        rd_lit(BASE + 32'h04, 32'hFFFF_FFFF, 32'd0, 1'b1, "mtime_hi_after_rst");
        chk("fifo_discarded", tx_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
